// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed hex driver for common-anode seven-segment digits.
// Shows a frame-coherent shadow copy of hex_in, with a dark guard interval at every digit switch.
module seven_seg_mux #(
    parameter int NUM_DIGITS       = 2,
    parameter int REFRESH_DIV      = 50000,
    parameter int GUARD            = 500,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_CNT = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};
    localparam logic [6:0]            SEG_OFF   = 7'b1111111;

    logic [CNT_W-1:0]        slot_cnt;
    logic                    primed;
    logic [4*NUM_DIGITS-1:0] sh_hex;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic                    sh_lz;

    logic                    at_slot_end;
    logic                    at_frame_end;
    logic                    capture;
    logic                    guard_on;
    logic                    digit_dark;
    logic                    run;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic [NUM_DIGITS-1:0]   one_hot;
    logic [3:0]              nibble;
    logic [6:0]              glyph;

    assign at_slot_end  = (slot_cnt == SLOT_LAST);
    assign at_frame_end = at_slot_end && (digit_idx == IDX_LAST);
    // The first frame after reset latches the inputs as soon as scanning starts.
    assign capture      = en && (!primed || at_frame_end);
    assign guard_on     = (slot_cnt < GUARD_CNT);

    // lead_zero[i]: nibble i and every more-significant nibble are zero; digit 0 never qualifies.
    always_comb begin
        lead_zero = '0;
        run       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run          = run & (sh_hex[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
    end

    always_comb begin
        one_hot            = '0;
        one_hot[digit_idx] = 1'b1;
        nibble             = sh_hex[{digit_idx, 2'b00} +: 4];
        digit_dark         = sh_blank[digit_idx] | (sh_lz & lead_zero[digit_idx]);
    end

    always_comb begin
        glyph = SEG_OFF;
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = SEG_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            primed      <= 1'b0;
            sh_hex      <= '0;
            sh_blank    <= '0;
            sh_lz       <= 1'b0;
            seg         <= SEG_OFF;
            anode       <= ANODE_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= capture;
            if (capture) begin
                sh_hex   <= hex_in;
                sh_blank <= blank;
                sh_lz    <= lz_suppress;
                primed   <= 1'b1;
            end
            if (en) begin
                if (at_slot_end) begin
                    slot_cnt  <= '0;
                    digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
                end else begin
                    slot_cnt <= slot_cnt + CNT_W'(1);
                end
            end
            // Output reflects the slot position sampled at this edge (one cycle of latency).
            if (en && !guard_on && !digit_dark) begin
                seg   <= glyph;
                anode <= one_hot ^ ANODE_OFF;
            end else begin
                seg   <= SEG_OFF;
                anode <= ANODE_OFF;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: directed scenarios plus random stimulus against a position-based model.
module tb_seven_seg_mux;
    localparam int N = 2;
    localparam int R = 4;
    localparam int G = 1;
    localparam logic [6:0] DEC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [6:0] DARK = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] hex_in;
    logic [1:0] blank;
    logic       lz_suppress;
    logic [6:0] seg;
    logic [1:0] anode;
    logic [0:0] digit_idx;
    logic       frame_start;

    int n_checks = 0;
    int n_errors = 0;

    // Model: scan position as one integer over the whole frame, plus the captured frame inputs.
    int         m_pos;
    bit         m_primed;
    logic [7:0] m_hex;
    logic [1:0] m_blank;
    logic       m_lz;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_fs;
    int         e_idx;
    logic [6:0] exp_q[$];

    seven_seg_mux #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD(G), .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .hex_in(hex_in), .blank(blank),
        .lz_suppress(lz_suppress), .seg(seg), .anode(anode),
        .digit_idx(digit_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic [7:0] h, input logic [1:0] b, input logic lz);
        en          = e;
        hex_in      = h;
        blank       = b;
        lz_suppress = lz;
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_primed = 1'b0;
        m_hex    = '0;
        m_blank  = '0;
        m_lz     = 1'b0;
        e_seg    = DARK;
        e_an     = 2'b11;
        e_fs     = 1'b0;
        e_idx    = 0;
    endtask

    task automatic model_edge();
        int d;
        int s;
        int nib;
        logic [1:0] oh;
        d     = m_pos / R;
        s     = m_pos % R;
        nib   = int'((m_hex >> (4 * d)) & 8'h0F);
        e_seg = DARK;
        e_an  = 2'b11;
        e_fs  = 1'b0;
        if (en) begin
            if (s >= G && !m_blank[d] && !(m_lz && d != 0 && (m_hex >> (4 * d)) == 8'h00)) begin
                e_seg = DEC[nib];
                oh    = '0;
                oh[d] = 1'b1;
                e_an  = ~oh;
            end
            if (!m_primed || m_pos == N * R - 1) begin
                m_hex    = hex_in;
                m_blank  = blank;
                m_lz     = lz_suppress;
                m_primed = 1'b1;
                e_fs     = 1'b1;
            end
            m_pos = (m_pos + 1) % (N * R);
        end
        e_idx = m_pos / R;
    endtask

    task automatic step();
        logic [6:0] ex;
        @(posedge clk);
        model_edge();
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("anode", 32'(anode), 32'(e_an));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("digit_idx", 32'(digit_idx), 32'(e_idx));
        check("no_x", 32'($isunknown({seg, anode, digit_idx, frame_start})), 32'd0);
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            check("seq_seg", 32'(seg), 32'(ex));
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 1'b0);
        model_reset();
        #1 reset = 1'b1;
        #2;
        check("rst_seg", 32'(seg), 32'(DARK));
        check("rst_anode", 32'(anode), 32'(2'b11));
        check("rst_idx", 32'(digit_idx), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Two frames of 8'h3A: guard cycle then "A" on digit 0, guard then "3" on digit 1.
        drive(1'b1, 8'h3A, 2'b00, 1'b0);
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(DARK);
            repeat (3) exp_q.push_back(7'b0001000);
            exp_q.push_back(DARK);
            repeat (3) exp_q.push_back(7'b0110000);
        end
        repeat (20) step();

        // Low nibble sweep, one full frame per value.
        for (int v = 0; v < 16; v++) begin
            drive(1'b1, {4'($urandom_range(0, 15)), 4'(v)}, 2'b00, 1'b0);
            repeat (N * R) step();
        end
        repeat (N * R) step();

        // Leading-zero suppression, including an all-zero value.
        drive(1'b1, 8'h05, 2'b00, 1'b1);
        repeat (16) step();
        drive(1'b1, 8'h00, 2'b00, 1'b1);
        repeat (16) step();

        // Input change in the middle of the digit 1 slot must not tear the frame.
        drive(1'b1, 8'h12, 2'b00, 1'b0);
        repeat (16) step();
        for (int k = 0; k < 8 && m_pos != 6; k++) step();
        drive(1'b1, 8'h34, 2'b00, 1'b0);
        repeat (16) step();

        // Freeze mid-slot for six cycles, then resume.
        for (int k = 0; k < 8 && m_pos != 2; k++) step();
        en = 1'b0;
        repeat (6) step();
        en = 1'b1;
        repeat (12) step();

        // Asynchronous reset between edges.
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        check("async_seg", 32'(seg), 32'(DARK));
        check("async_anode", 32'(anode), 32'(2'b11));
        check("async_idx", 32'(digit_idx), 32'd0);
        check("async_fs", 32'(frame_start), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (12) step();

        // Random stimulus.
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 9) != 0, 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                  1'($urandom_range(0, 1)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits that share one active-low segment bus. The block decodes a packed hex word to segment patterns and scans the digits at a programmable refresh rate. It inserts a blanking guard interval at each digit switch to prevent ghosting, and supports per-digit blanking and leading-zero suppression. It sits between the datapath (which presents hex nibbles) and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (1..8).
REFRESH_DIV, 50000, clk cycles each digit is selected (>= GUARD+1).
GUARD, 500, cycles at the start of each digit slot with segments and anodes all off (>= 0).
ANODE_ACTIVE_LOW, 1, 1: anode enable driven low; 0: driven high.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  1 = scan; 0 = hold scan position and force display dark
hex_in  input  4*NUM_DIGITS  packed nibbles; nibble i = hex_in[4i+3:4i] drives digit i, where digit 0 is rightmost
blank  input  NUM_DIGITS  bit i = 1 forces digit i dark
lz_suppress  input  1  1 = blank leading zero digits
seg  output  7  active-low segments {g,f,e,d,c,b,a}; seg[0]=a
anode  output  NUM_DIGITS  one-hot digit enable, polarity per ANODE_ACTIVE_LOW
digit_idx  output  clog2(NUM_DIGITS), min 1  index of the currently selected digit
frame_start  output  1  1-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (async assert, sync-safe release). Outputs and state take these values:
  - seg = 7'b1111111.
  - anode = all inactive.
  - digit_idx = 0.
  - frame_start = 0.
  - Slot counter = 0.
  - Shadow register = 0.
- Slot counter: counts 0..REFRESH_DIV-1 while en=1.
  - At REFRESH_DIV-1 it wraps to 0, and digit_idx advances.
  - digit_idx wraps from NUM_DIGITS-1 to 0.
- Shadow capture: hex_in, blank and lz_suppress are captured into a shadow register on the cycle digit_idx wraps to 0. The same cycle asserts frame_start for 1 cycle. The first frame after reset captures on the first en=1 cycle.
  - A whole frame therefore shows one coherent value; there is no tearing.
- Guard: while slot counter < GUARD, seg = all off and anode = all inactive. Otherwise only anode[digit_idx] is active.
- Outputs are registered: seg and anode reflect slot counter and digit_idx with 1-cycle latency. digit_idx itself is the current registered value.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Dark digit: seg = 1111111 and its anode stays inactive when any of these holds:
  - the shadow blank bit for that digit is 1;
  - shadow lz_suppress=1, the nibble is 0, all more-significant nibbles are 0, and the digit is not digit 0. Digit 0 always shows, so a value of 0 displays "0".
- en=0: counters freeze at their current values; seg and anode go dark on the next cycle. On en returning to 1, scanning resumes from the frozen position.
- Reset mid-scan: outputs go dark immediately (async). Scanning restarts at digit 0 and count 0.
- NUM_DIGITS=1: digit_idx is constant 0, and frame_start pulses every REFRESH_DIV cycles.
- GUARD=0: no dark interval.

Test Plan:
1. Params NUM_DIGITS=2, REFRESH_DIV=4, GUARD=1. hex_in=8'h3A, en=1 after reset.
   - Expected: frame_start at the first capture, then 1 pulse every 8 cycles.
   - Digit 0 slot: 1 dark cycle, then 3 cycles of seg=0001000 with anode=2'b10.
   - Digit 1 slot: seg=0110000 with anode=2'b01.
2. Sweep hex_in[3:0] through 0..F, each held for a full frame.
   - Expected: digit 0 seg matches the decode table for every value. No X appears on any output.
3. hex_in=8'h05 with lz_suppress=1, then hex_in=8'h00 with lz_suppress=1.
   - 8'h05: digit 1 dark (anode inactive, seg=1111111); digit 0 = 0010010.
   - 8'h00: digit 0 = 1000000.
4. Change hex_in from 8'h12 to 8'h34 in the middle of the digit 1 slot.
   - Expected: the rest of that frame still shows 2 on digit 0 and 1 on digit 1. The next frame shows 4 and 3.
5. Drop en to 0 for 6 cycles mid-slot.
   - Expected: output goes dark 1 cycle later. digit_idx and the slot count hold.
   - On en=1, the remaining slot cycles complete before digit_idx advances.
6. Assert reset asynchronously between clock edges mid-scan.
   - Expected: seg=1111111, anode=2'b11, digit_idx=0, frame_start=0 immediately, not at the next edge.
   - After release, the scan restarts from digit 0.
